// File: rtl/rv32i_irq_controller_if.sv
// Core/CSR-side bus of the interrupt controller: word-wide config port plus the offer handshake.
// Handshake: the controller holds irq_valid_o and irq_id_o steady until irq_ack_i is seen with valid high;
// ack without valid and complete outside service are ignored by the controller.
interface rv32i_irq_controller_if #(
  parameter int ID_W = 3,
  parameter int XLEN = 32
);
  logic            cfg_we_i;
  logic [1:0]      cfg_addr_i;
  logic [XLEN-1:0] cfg_wdata_i;
  logic [XLEN-1:0] cfg_rdata_o;
  logic            irq_valid_o;
  logic [ID_W-1:0] irq_id_o;
  logic            irq_ack_i;
  logic            irq_complete_i;
  logic            busy_o;

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_wdata_i, irq_ack_i, irq_complete_i,
    input  cfg_rdata_o, irq_valid_o, irq_id_o, busy_o
  );

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_wdata_i, irq_ack_i, irq_complete_i,
    output cfg_rdata_o, irq_valid_o, irq_id_o, busy_o
  );
endinterface

// File: rtl/rv32i_irq_controller.sv
// Priority interrupt controller: synchronizes requests, latches edge/level pending bits,
// arbitrates by programmable priority and offers one source at a time to the core.
module rv32i_irq_controller #(
  parameter int NUM_SRC = 5,
  parameter int PRIO_W  = 2,
  parameter int ID_W    = 3,
  parameter int XLEN    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_SRC-1:0]  irq_i,
  rv32i_irq_controller_if.slave bus,
  output logic [1:0]          dbg_state_o
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OFFER   = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [NUM_SRC-1:0]        r_sync1, r_sync2, r_sync3;
  logic [NUM_SRC-1:0]        r_en, r_edge, r_pend;
  logic [NUM_SRC*PRIO_W-1:0] r_prio;
  logic [1:0]                r_state;
  logic [ID_W-1:0]           r_id;

  logic [NUM_SRC-1:0]        w_rise, w_w1c, w_ack_clr, w_clr, w_elig, w_pend_nxt;
  logic                      w_ack_fire, w_any;
  logic [ID_W-1:0]           w_win_id;
  logic [PRIO_W-1:0]         w_best;
  logic                      w_unused;

  assign w_unused   = ^bus.cfg_wdata_i;
  assign w_rise     = r_sync2 & ~r_sync3;
  assign w_ack_fire = (r_state == ST_OFFER) && bus.irq_ack_i;
  assign w_w1c      = (bus.cfg_we_i && bus.cfg_addr_i == 2'd3) ? bus.cfg_wdata_i[NUM_SRC-1:0] : '0;
  assign w_clr      = w_w1c | w_ack_clr;
  // Edge bits: a fresh rising edge wins over any clear in the same cycle.
  assign w_pend_nxt = (r_edge & (w_rise | (r_pend & ~w_clr))) | (~r_edge & r_sync2);
  assign w_elig     = r_pend & r_en;

  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ack_clr[i] = w_ack_fire && (r_id == ID_W'(i + 1));
    end
  end

  // Strict greater-than keeps the lowest index on ties and excludes priority 0.
  always_comb begin
    w_any    = 1'b0;
    w_win_id = '0;
    w_best   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_elig[i] && (r_prio[i*PRIO_W +: PRIO_W] > w_best)) begin
        w_best   = r_prio[i*PRIO_W +: PRIO_W];
        w_win_id = ID_W'(i + 1);
        w_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_pend  <= '0;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pend  <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en   <= '0;
      r_edge <= '0;
      r_prio <= '0;
    end else if (bus.cfg_we_i) begin
      case (bus.cfg_addr_i)
        2'd0:    r_en   <= bus.cfg_wdata_i[NUM_SRC-1:0];
        2'd1:    r_edge <= bus.cfg_wdata_i[NUM_SRC-1:0];
        2'd2:    r_prio <= bus.cfg_wdata_i[NUM_SRC*PRIO_W-1:0];
        default: ;
      endcase
    end
  end

  // The offered id is frozen from IDLE until completion; nothing else may change it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_OFFER;
            r_id    <= w_win_id;
          end
        end
        ST_OFFER: begin
          if (bus.irq_ack_i) r_state <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (bus.irq_complete_i) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_id    <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.cfg_rdata_o = '0;
    case (bus.cfg_addr_i)
      2'd0:    bus.cfg_rdata_o = XLEN'(r_en);
      2'd1:    bus.cfg_rdata_o = XLEN'(r_edge);
      2'd2:    bus.cfg_rdata_o = XLEN'(r_prio);
      default: bus.cfg_rdata_o = XLEN'(r_pend);
    endcase
  end

  assign bus.irq_valid_o = (r_state == ST_OFFER);
  assign bus.irq_id_o    = r_id;
  assign bus.busy_o      = (r_state != ST_IDLE);
  assign dbg_state_o     = r_state;
endmodule

// File: tb/tb_rv32i_irq_controller.sv
// Directed bench for rv32i_irq_controller: vector table for the edge-latency path plus
// hand-written sequences for priority, offer stability, set/clear races, re-offer and reset.
module tb_rv32i_irq_controller;
  logic       clk = 1'b0;
  logic       rst_ni;
  logic [4:0] irq;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] exp_q[$];

  rv32i_irq_controller_if #(.ID_W(3), .XLEN(32)) bus ();

  rv32i_irq_controller #(.NUM_SRC(5), .PRIO_W(2), .ID_W(3), .XLEN(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .irq_i       (irq),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [4:0]  irq;
    logic        ack;
    logic        cpl;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic [2:0]  exp_id;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic we, logic [1:0] a, logic [31:0] wd, logic [4:0] ir,
                              logic ack, logic cpl, logic [31:0] rd, logic v,
                              logic [2:0] id, logic b);
    vec_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.irq = ir; t.ack = ack; t.cpl = cpl;
    t.exp_rd = rd; t.exp_valid = v; t.exp_id = id; t.exp_busy = b;
    return t;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we_i = 1'b1; bus.cfg_addr_i = a; bus.cfg_wdata_i = d;
    cyc();
    bus.cfg_we_i = 1'b0; bus.cfg_wdata_i = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.cfg_addr_i = a;
    #1;
    d = bus.cfg_rdata_o;
  endtask

  task automatic pulse_ack();
    bus.irq_ack_i = 1'b1; cyc(); bus.irq_ack_i = 1'b0;
  endtask

  task automatic pulse_cpl();
    bus.irq_complete_i = 1'b1; cyc(); bus.irq_complete_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.irq_valid_o && n < 20) begin
      cyc();
      n++;
    end
    check(name, bus.irq_valid_o, 1);
  endtask

  task automatic check_outs(input string name, input logic v, input logic [2:0] id, input logic b);
    check({name, "_valid"}, bus.irq_valid_o, v);
    check({name, "_id"}, bus.irq_id_o, id);
    check({name, "_busy"}, bus.busy_o, b);
  endtask

  initial begin
    logic [31:0] d;
    int          seen;

    rst_ni = 1'b0; irq = '0;
    bus.cfg_we_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_wdata_i = '0;
    bus.irq_ack_i = 1'b0; bus.irq_complete_i = 1'b0;

    // reset state
    cycn(2);
    check_outs("reset", 0, 0, 0);
    check("reset_state", dbg_state, 0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check($sformatf("reset_rd%0d", a), d, 0);
    end
    rst_ni = 1'b1;
    cyc();

    // edge latency: irq[0] high before E1 (vec3), pending after E3 (vec5), offer after E4 (vec6)
    vecs[0]  = mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(1, 2, 1, 0, 0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 3, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[6]  = mk(0, 3, 0, 0, 0, 0, 1, 1, 1, 1);
    vecs[7]  = mk(0, 3, 0, 0, 0, 0, 1, 1, 1, 1);
    vecs[8]  = mk(0, 3, 0, 0, 1, 0, 0, 0, 1, 1);
    vecs[9]  = mk(0, 3, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[10] = mk(0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk(0, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 3, 0, 0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      bus.cfg_we_i = vecs[i].we; bus.cfg_addr_i = vecs[i].addr; bus.cfg_wdata_i = vecs[i].wdata;
      irq = vecs[i].irq; bus.irq_ack_i = vecs[i].ack; bus.irq_complete_i = vecs[i].cpl;
      cyc();
      check($sformatf("vec%0d_rd", i), bus.cfg_rdata_o, vecs[i].exp_rd);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_id, vecs[i].exp_busy);
    end
    bus.cfg_we_i = 1'b0; bus.irq_ack_i = 1'b0; bus.irq_complete_i = 1'b0;

    // priority and tie: src1=2, src3=3, src4=3, src2=0, all level
    cfg_wr(1, 32'h0);
    cfg_wr(2, 32'h3C8);
    cfg_wr(0, 32'h1F);
    rd(2, d);
    check("prio_rd", d, 32'h3C8);
    exp_q.push_back(3'd4); exp_q.push_back(3'd5); exp_q.push_back(3'd2);
    irq = 5'h1F;
    wait_valid("prio_offer1");
    check("prio_id1", bus.irq_id_o, exp_q.pop_front());
    pulse_ack();
    irq = 5'h17;
    cycn(4);
    pulse_cpl();
    wait_valid("prio_offer2");
    check("prio_id2", bus.irq_id_o, exp_q.pop_front());
    pulse_ack();
    irq = 5'h07;
    cycn(4);
    pulse_cpl();
    wait_valid("prio_offer3");
    check("prio_id3", bus.irq_id_o, exp_q.pop_front());
    pulse_ack();
    irq = 5'h05;
    cycn(4);
    pulse_cpl();
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (bus.irq_valid_o) seen++;
    end
    check("prio0_never_offered", seen, 0);
    irq = '0;
    cycn(4);

    // offer stability: id=2 offered, then higher-priority src0 raised and ENABLE[1] cleared
    cfg_wr(2, 32'h07);
    cfg_wr(0, 32'h02);
    irq = 5'h02;
    wait_valid("stab_offer");
    check("stab_id", bus.irq_id_o, 2);
    irq = 5'h01;
    cfg_wr(0, 32'h01);
    cycn(6);
    check_outs("stab_hold", 1, 2, 1);
    pulse_ack();
    check_outs("stab_service", 0, 2, 1);
    check("stab_state", dbg_state, 2);
    pulse_cpl();
    wait_valid("stab_next_offer");
    check("stab_next_id", bus.irq_id_o, 1);
    pulse_ack();
    irq = '0;
    cycn(4);
    pulse_cpl();
    cycn(4);
    check_outs("stab_idle", 0, 0, 0);

    // simultaneous: new edge on src0 in the ack cycle, then W1C together with a new edge
    cfg_wr(1, 32'h1);
    cfg_wr(2, 32'h1);
    cfg_wr(0, 32'h1);
    irq = 5'h01; cycn(3); irq = '0;
    wait_valid("sim_offer");
    check("sim_id", bus.irq_id_o, 1);
    cycn(4);
    irq = 5'h01;
    cycn(2);
    bus.irq_ack_i = 1'b1;
    cyc();
    bus.irq_ack_i = 1'b0; irq = '0;
    check_outs("sim_after_ack", 0, 1, 1);
    rd(3, d);
    check("sim_pend_after_ack", d, 1);
    cycn(3);
    pulse_cpl();
    wait_valid("sim_reoffer");
    check("sim_reoffer_id", bus.irq_id_o, 1);
    cfg_wr(3, 32'h1);
    rd(3, d);
    check("w1c_clears", d, 0);
    cycn(2);
    irq = 5'h01;
    cycn(2);
    bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 2'd3; bus.cfg_wdata_i = 32'h1;
    cyc();
    bus.cfg_we_i = 1'b0; bus.cfg_wdata_i = '0; irq = '0;
    rd(3, d);
    check("w1c_vs_edge", d, 1);
    check_outs("w1c_offer_kept", 1, 1, 1);
    pulse_ack();
    rd(3, d);
    check("ack_clears_pend", d, 0);
    pulse_cpl();
    cycn(4);
    check_outs("sim_no_reoffer", 0, 0, 0);

    // level re-offer and strobes in the wrong state
    cfg_wr(1, 32'h0);
    cfg_wr(2, 32'h10);
    cfg_wr(0, 32'h04);
    irq = 5'h04;
    wait_valid("lvl_offer");
    check("lvl_id", bus.irq_id_o, 3);
    pulse_ack();
    check_outs("lvl_service", 0, 3, 1);
    pulse_ack();
    check_outs("lvl_ack_in_service", 0, 3, 1);
    pulse_cpl();
    check_outs("lvl_after_cpl", 0, 0, 0);
    cyc();
    check_outs("lvl_reoffer", 1, 3, 1);
    pulse_cpl();
    check_outs("lvl_cpl_in_offer", 1, 3, 1);
    bus.irq_ack_i = 1'b1; bus.irq_complete_i = 1'b1;
    cyc();
    bus.irq_ack_i = 1'b0; bus.irq_complete_i = 1'b0;
    check_outs("lvl_ack_and_cpl", 0, 3, 1);
    cyc();
    check_outs("lvl_still_service", 0, 3, 1);

    // reset mid-SERVICE
    rst_ni = 1'b0;
    cyc();
    check_outs("midrst", 0, 0, 0);
    check("midrst_state", dbg_state, 0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check($sformatf("midrst_rd%0d", a), d, 0);
    end
    irq = '0;
    rst_ni = 1'b1;
    cycn(6);
    check_outs("post_rst_idle", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rv32i_irq_controller.md
# rv32i_irq_controller

Programmable interrupt controller between peripheral interrupt lines and the rv32i core's trap logic. Synchronizes raw requests, latches them as edge- or level-triggered pending bits, arbitrates by programmable priority, offers a single winning source to the core over a valid/ack handshake, and holds it in service until the core signals completion. Configuration is a small word-wide register port driven from the CSR path.

## Interface
- NUM_SRC, 5, number of interrupt sources (1..31)
- PRIO_W, 2, priority field width per source; priority 0 = never taken
- ID_W, 3, width of source ID; must satisfy 2^ID_W > NUM_SRC
- XLEN, 32, config data width; must be >= NUM_SRC*PRIO_W

- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- irq_i  in  NUM_SRC  raw asynchronous peripheral requests
- cfg_we_i  in  1  config write strobe
- cfg_addr_i  in  2  0=ENABLE, 1=EDGE, 2=PRIO, 3=PENDING
- cfg_wdata_i  in  XLEN  write data
- cfg_rdata_o  out  XLEN  combinational read of cfg_addr_i, unused bits 0
- irq_valid_o  out  1  offer to core
- irq_id_o  out  ID_W  offered/in-service source, index+1; 0 = none
- irq_ack_i  in  1  core accepts offer
- irq_complete_i  in  1  core finished handler
- busy_o  out  1  state != IDLE

## Operation
- Registers: ENABLE[NUM_SRC-1:0]; EDGE[NUM_SRC-1:0] (1 = rising-edge, 0 = level); PRIO packed, source i at bits [i*PRIO_W +: PRIO_W]; PENDING read-only except write-1-to-clear of edge bits (W1C has no effect on level bits).
- Each irq_i passes a 2-flop synchronizer; third flop holds the previous synced value for edge detect.
- Edge source: pending set on synced 0->1; cleared by ack of that source or W1C. Set beats clear in the same cycle.
- Level source: pending = synced value, registered each cycle.
- Eligible = pending & ENABLE & (PRIO != 0). Winner = highest PRIO; ties to lowest index.
- FSM, 3 states:
  - IDLE: if any eligible, latch winner into irq_id_o -> OFFER.
  - OFFER: irq_valid_o=1. irq_id_o stable; config changes, pending clears or new higher-priority requests do not alter or withdraw the offer. On irq_ack_i -> SERVICE; winner's edge-pending bit clears.
  - SERVICE: irq_id_o held, irq_valid_o=0, no new offer (no nesting). On irq_complete_i -> IDLE, irq_id_o <= 0.
- irq_ack_i outside OFFER and irq_complete_i outside SERVICE ignored; ack and complete together in OFFER -> SERVICE only.
- Level source still asserted after completion is re-offered through normal arbitration.

## Timing
- Reset values: all registers 0, synchronizers 0, state IDLE, irq_valid_o=0, irq_id_o=0, busy_o=0, cfg_rdata_o reflects zeroed registers.
- Reset mid-operation: immediate return to IDLE, all pending lost.
- Latency: irq_i high before edge E1 -> synced after E2 -> PENDING bit after E3 -> irq_valid_o and irq_id_o after E4 (4 cycles, enabled source, controller idle).
- Config write takes effect at the next edge; arbitration in that cycle uses old values.
- Ack at edge Ea -> SERVICE after Ea; complete at Ec -> IDLE after Ec; earliest next offer after Ec+1.
- Pulses shorter than one clock may be missed; sources must hold ≥2 cycles.

## Test plan
- Reset: assert rst_ni=0 mid-SERVICE -> next cycle valid=0, id=0, busy=0, all cfg reads 0.
- Edge latency: ENABLE=1, EDGE=1, PRIO[0]=1, pulse irq_i[0] 3 cycles -> PENDING=0x01 after E3, valid=1 id=1 after E4; ack -> PENDING=0, busy=1; complete -> id=0, no re-offer.
- Priority/tie: ENABLE=0x1F, PRIO src1=2, src3=3, src4=3, all level high -> id=4; complete with src3 dropped -> id=5 offered; PRIO src2=0 never offered.
- Offer stability: offer id=2 pending, raise higher-priority src0 and clear ENABLE[1] -> id stays 2, valid stays 1 until ack.
- Simultaneous: new edge on src0 in the same cycle as its ack -> PENDING[0] remains 1, re-offered after complete; W1C on src0 together with new edge -> bit stays 1.
- Level re-offer: level src2 held high through handler -> after complete, offered again with id=3 two cycles later; ack/complete strobes in wrong states change nothing.
